// File: rtl/vga_pkg.sv
// Shared VGA text-rendering definitions: palette colours, glyph codes and bus widths.
package vga_pkg;

  localparam int RGB_W  = 12;
  localparam int ROM_AW = 11;

  // Palette colours, {R[3:0], G[3:0], B[3:0]}
  localparam logic [RGB_W-1:0] COLOR_YELLOW = 12'hFF0;
  localparam logic [RGB_W-1:0] COLOR_WHITE  = 12'hFFF;
  localparam logic [RGB_W-1:0] COLOR_CYAN   = 12'h0FF;
  localparam logic [RGB_W-1:0] COLOR_NAVY   = 12'h008;
  localparam logic [RGB_W-1:0] COLOR_RED    = 12'hF00;
  localparam logic [RGB_W-1:0] COLOR_BLACK  = 12'h000;

  // Palette index whose ink alternates with the blink phase
  localparam logic [3:0] COLOR_BLINK_IDX = 4'd15;

  // Glyph code of the solid fill block (every row 8'hFF)
  localparam logic [6:0] FONT_SOLID = 7'h0a;

  // Horizontal scaling selector; only FS_X2 doubles, the others render native
  typedef enum logic [1:0] {
    FS_NATIVE0 = 2'd0,
    FS_X1      = 2'd1,
    FS_X2      = 2'd2,
    FS_NATIVE3 = 2'd3
  } font_size_t;

endpackage

// File: rtl/font_rom.sv
// 2048x8 font ROM, address {char[6:0], row[3:0]}, synchronous read with one cycle
// of latency. Glyph bitmaps are held as constants so the ROM needs no external
// initialisation file; unlisted codes read as blank rows.
module font_rom
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0]        data
);

  // Each glyph is 16 rows of 8 bits, row 0 in the top byte, MSB = leftmost pixel
  localparam logic [127:0] GLYPH_0 = 128'h0000_3C66_666E_7666_6666_3C00_0000_0000;
  localparam logic [127:0] GLYPH_1 = 128'h0000_1838_7818_1818_1818_7E00_0000_0000;
  localparam logic [127:0] GLYPH_2 = 128'h0000_3C66_060C_1830_6066_7E00_0000_0000;
  localparam logic [127:0] GLYPH_3 = 128'h0000_3C66_0606_1C06_0666_3C00_0000_0000;
  localparam logic [127:0] GLYPH_4 = 128'h0000_0C1C_3C6C_CCFE_0C0C_1E00_0000_0000;
  localparam logic [127:0] GLYPH_5 = 128'h0000_7E60_607C_0606_0666_3C00_0000_0000;
  localparam logic [127:0] GLYPH_6 = 128'h0000_1C30_607C_6666_6666_3C00_0000_0000;
  localparam logic [127:0] GLYPH_7 = 128'h0000_7E66_060C_1818_1818_1800_0000_0000;
  localparam logic [127:0] GLYPH_8 = 128'h0000_3C66_6666_3C66_6666_3C00_0000_0000;
  localparam logic [127:0] GLYPH_9 = 128'h0000_3C66_6666_3E06_060C_3800_0000_0000;
  localparam logic [127:0] GLYPH_A = 128'h0000_183C_6666_7E66_6666_6600_0000_0000;
  localparam logic [127:0] GLYPH_B = 128'h0000_7C66_6666_7C66_6666_7C00_0000_0000;
  localparam logic [127:0] GLYPH_C = 128'h0000_3C66_6060_6060_6066_3C00_0000_0000;
  localparam logic [127:0] GLYPH_D = 128'h0000_786C_6666_6666_666C_7800_0000_0000;
  localparam logic [127:0] GLYPH_E = 128'h0000_7E60_6060_7C60_6060_7E00_0000_0000;
  localparam logic [127:0] GLYPH_F = 128'h0000_7E60_6060_7C60_6060_6000_0000_0000;

  function automatic logic [7:0] glyph_row(input logic [6:0] ch, input logic [3:0] row);
    logic [127:0] g;
    g = '0;
    case (ch)
      FONT_SOLID: g = '1;
      7'h30: g = GLYPH_0;
      7'h31: g = GLYPH_1;
      7'h32: g = GLYPH_2;
      7'h33: g = GLYPH_3;
      7'h34: g = GLYPH_4;
      7'h35: g = GLYPH_5;
      7'h36: g = GLYPH_6;
      7'h37: g = GLYPH_7;
      7'h38: g = GLYPH_8;
      7'h39: g = GLYPH_9;
      7'h41: g = GLYPH_A;
      7'h42: g = GLYPH_B;
      7'h43: g = GLYPH_C;
      7'h44: g = GLYPH_D;
      7'h45: g = GLYPH_E;
      7'h46: g = GLYPH_F;
      default: g = '0;
    endcase
    g = g << {row, 3'b000};
    return g[127:120];
  endfunction

  // Registered ROM read
  always_ff @(posedge clk) begin
    data <= glyph_row(addr[10:4], addr[3:0]);
  end

endmodule

// File: rtl/pixel_render.sv
// Pixel renderer: font ROM lookup, column bit select, palette mapping and a
// registered 12-bit RGB output, two clocks behind its inputs. Palette entry 15
// blinks with a frame-counted phase.
module pixel_render
  import vga_pkg::*;
#(
  parameter int               BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] BG_RGB       = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        color_addr,
  input  logic [1:0]        font_size,
  input  logic              dp,
  input  logic [9:0]        pixelx,
  input  logic              video_on,
  input  logic              frame_tick,
  output logic [RGB_W-1:0]  rgb
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [2:0]       col_idx_p0;
  logic [7:0]       rom_row_p1;
  logic [3:0]       color_addr_p1;
  logic [2:0]       col_idx_p1;
  logic             dp_p1;
  logic             vld_p1;
  logic             glyph_bit_p1;
  logic [RGB_W-1:0] rgb_next;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             unused_pixelx;

  // Columns beyond one glyph cell are irrelevant to bit selection
  assign unused_pixelx = ^pixelx[9:4];

  function automatic logic [RGB_W-1:0] palette(input logic [3:0] idx, input logic phase);
    logic [RGB_W-1:0] c;
    c = COLOR_BLACK;
    case (idx)
      4'd0:            c = COLOR_YELLOW;
      4'd1:            c = COLOR_WHITE;
      4'd2:            c = COLOR_CYAN;
      4'd3:            c = COLOR_NAVY;
      4'd4:            c = COLOR_RED;
      COLOR_BLINK_IDX: c = phase ? COLOR_WHITE : BG_RGB;
      default:         c = COLOR_BLACK;
    endcase
    return c;
  endfunction

  // ---- stage 0: ROM address presented, per-pixel attributes captured ----

  // Double-width text steps the glyph column every second pixel
  always_comb begin
    col_idx_p0 = pixelx[2:0];
    if (font_size == FS_X2) col_idx_p0 = pixelx[3:1];
  end

  font_rom u_font_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_row_p1)
  );

  // Align attributes with the ROM read so they meet its data in stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      color_addr_p1 <= '0;
      col_idx_p1    <= '0;
      dp_p1         <= 1'b0;
      vld_p1        <= 1'b0;
    end else begin
      color_addr_p1 <= color_addr;
      col_idx_p1    <= col_idx_p0;
      dp_p1         <= dp;
      vld_p1        <= video_on;
    end
  end

  // Frame counter driving the blink phase; a held tick counts every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---- stage 1: glyph bit select and colour mapping ----

  // Blank outside the active area or drawn items; glyph-off pixels get the background
  always_comb begin
    glyph_bit_p1 = rom_row_p1[3'd7 - col_idx_p1];
    rgb_next     = COLOR_BLACK;
    if (vld_p1 && dp_p1) begin
      rgb_next = glyph_bit_p1 ? palette(color_addr_p1, blink_phase) : BG_RGB;
    end
  end

  // ---- stage 2: registered output ----

  // Output register feeding the VGA pins
  always_ff @(posedge clk) begin
    if (reset) rgb <= '0;
    else       rgb <= rgb_next;
  end

endmodule

// File: tb/tb_pixel_render.sv
// Scoreboard bench for pixel_render: each driven pixel pushes its expected colour,
// which is compared when the pixel emerges from the two-clock pipeline.
module tb_pixel_render;
  import vga_pkg::*;

  localparam int          BF = 2;
  localparam logic [11:0] BG = 12'h123;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] rom_addr = '0;
  logic [3:0]  color_addr = '0;
  logic [1:0]  font_size = 2'd1;
  logic        dp = 1'b0;
  logic [9:0]  pixelx = '0;
  logic        video_on = 1'b0;
  logic        frame_tick = 1'b0;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  pixel_render #(.BLINK_FRAMES(BF), .BG_RGB(BG)) dut (
    .clk        (clk),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .color_addr (color_addr),
    .font_size  (font_size),
    .dp         (dp),
    .pixelx     (pixelx),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .rgb        (rgb)
  );

  typedef struct {
    int          cyc;
    logic [11:0] exp;
    logic        chk;
    string       tag;
  } sb_t;

  sb_t q[$];
  sb_t mon_e;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  ticks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ink(input logic [3:0] idx, input logic ph);
    case (idx)
      4'd0:  return 12'hFF0;
      4'd1:  return 12'hFFF;
      4'd2:  return 12'h0FF;
      4'd3:  return 12'h008;
      4'd4:  return 12'hF00;
      4'd15: return ph ? 12'hFFF : BG;
      default: return 12'h000;
    endcase
  endfunction

  // Only the glyph rows this bench draws from are known here
  function automatic logic [7:0] known_row(input logic [6:0] ch, input logic [3:0] rw);
    if (ch == 7'h0a) return 8'hFF;
    if (ch == 7'h30 && rw == 4'd3) return 8'h66;
    return 8'h00;
  endfunction

  task automatic drive(input string tag, input logic rst_i, input logic [6:0] ch,
                       input logic [3:0] rw, input logic [3:0] col, input logic dp_i,
                       input logic [9:0] px, input logic vo, input logic [1:0] fs,
                       input logic tick, input logic chk);
    sb_t e;
    sb_t t;
    logic [7:0] r;
    logic [2:0] c;
    logic ph;
    @(posedge clk);
    #1;
    reset = rst_i; rom_addr = {ch, rw}; color_addr = col; dp = dp_i;
    pixelx = px; video_on = vo; font_size = fs; frame_tick = tick;
    if (rst_i) ticks = 0;
    else if (tick) ticks++;
    ph = ((ticks / BF) % 2) == 1;
    c = (fs == 2'd2) ? px[3:1] : px[2:0];
    r = known_row(ch, rw);
    if (rst_i || !vo || !dp_i) e.exp = 12'h000;
    else e.exp = r[3'd7 - c] ? ink(col, ph) : BG;
    // Reset on this edge also clears the output of the previous pixel
    if (rst_i && q.size() > 0 && q[q.size()-1].cyc == cyc - 1) begin
      t = q[q.size()-1];
      t.exp = 12'h000;
      q[q.size()-1] = t;
    end
    e.cyc = cyc; e.chk = chk; e.tag = tag;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.chk) check_val(mon_e.tag, rgb, mon_e.exp);
    end
  end

  initial begin
    logic [6:0] ch;
    logic [3:0] rw;
    int k;

    @(posedge clk);
    #1;
    check_val("reset_state", rgb, 12'h000);

    for (int i = 0; i < 3; i++)
      drive("reset_hold", 1'b1, 7'($urandom), 4'($urandom), 4'($urandom), 1'b1,
            10'($urandom), 1'b1, 2'($urandom), 1'b0, 1'b1);

    drive("solid_red", 1'b0, 7'h0a, 4'd5, 4'd4, 1'b1, 10'd100, 1'b1, 2'd1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++)
      drive("scan_x1", 1'b0, 7'h30, 4'd3, 4'd2, 1'b1, 10'(i), 1'b1, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      drive("scan_x2", 1'b0, 7'h30, 4'd3, 4'd2, 1'b1, 10'(i), 1'b1, 2'd2, 1'b0, 1'b1);
    for (int i = 8; i < 16; i++)
      drive("scan_fs3", 1'b0, 7'h30, 4'd3, 4'd2, 1'b1, 10'(i), 1'b1, 2'd3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      drive("scan_fs0", 1'b0, 7'h30, 4'd3, 4'd2, 1'b1, 10'(i), 1'b1, 2'd0, 1'b0, 1'b1);

    for (int i = 0; i < 15; i++)
      drive("palette", 1'b0, 7'h0a, 4'd0, 4'(i), 1'b1, 10'd200, 1'b1, 2'd1, 1'b0, 1'b1);

    drive("glyph_off_bg", 1'b0, 7'h20, 4'd7, 4'd1, 1'b1, 10'd3, 1'b1, 2'd1, 1'b0, 1'b1);
    drive("dp_low", 1'b0, 7'h0a, 4'd7, 4'd1, 1'b0, 10'd3, 1'b1, 2'd1, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++)
      drive("blanking", 1'b0, 7'h0a, 4'd2, 4'd1, 1'b1, 10'(300 + i), (i < 10), 2'd1, 1'b0, 1'b1);

    for (int t = 0; t <= 4; t++) begin
      if (t > 0)
        drive("blink_tick", 1'b0, 7'h0a, 4'd0, 4'd15, 1'b1, 10'd0, 1'b0, 2'd1, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++)
        drive("blink", 1'b0, 7'h0a, 4'd0, 4'd15, 1'b1, 10'(i), 1'b1, 2'd1, 1'b0, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      ch = (k == 0) ? 7'h0a : ((k == 1) ? 7'h30 : 7'h20);
      rw = (k == 1) ? 4'd3 : 4'($urandom);
      drive("random", 1'b0, ch, rw, 4'($urandom), 1'($urandom), 10'($urandom),
            1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
    end

    // Bring the blink phase to a known 1 so the mid-frame reset must clear it
    while (((ticks / BF) % 2) != 1)
      drive("pre_tick", 1'b0, 7'h0a, 4'd0, 4'd15, 1'b1, 10'd0, 1'b0, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      drive("pre_reset_run", 1'b0, 7'h0a, 4'd1, 4'd15, 1'b1, 10'(i), 1'b1, 2'd1, 1'b0, 1'b1);
    check_val("phase_before_reset", {11'b0, dut.blink_phase}, 12'h001);
    for (int i = 0; i < 2; i++)
      drive("mid_reset", 1'b1, 7'h0a, 4'd1, 4'd15, 1'b1, 10'(i), 1'b1, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      drive("post_reset_run", 1'b0, 7'h0a, 4'd1, 4'd15, 1'b1, 10'(i), 1'b1, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      drive("post_reset_red", 1'b0, 7'h0a, 4'd1, 4'd4, 1'b1, 10'(i), 1'b1, 2'd1, 1'b0, 1'b1);
    check_val("phase_after_reset", {11'b0, dut.blink_phase}, 12'h000);

    for (int i = 0; i < 3; i++)
      drive("idle", 1'b0, 7'h00, 4'd0, 4'd0, 1'b0, 10'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check_val("drain", 12'(q.size()), 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
